contador: RTL and testbench

//   Free-running up-counter that advances once per clock while out of reset.

---
 rtl/contador.sv | 54 +++++
 tb/tb_contador.sv | 136 +++++++++++++
 2 files changed

// File: rtl/contador.sv
// Free-running up-counter with synchronous active-high reset.
// Wraps to RESET_VAL once the next increment would pass MAX_VAL.
module contador #(
    parameter int unsigned     WIDTH     = 16,
    parameter longint unsigned STEP      = 1,
    parameter longint unsigned RESET_VAL = 0,
    parameter longint unsigned MAX_VAL   = (64'd1 << WIDTH) - 64'd1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] count
);

    if (WIDTH < 1 || WIDTH > 63) begin : g_bad_width
        $error("contador: WIDTH must be in 1..63");
    end
    if (STEP < 1 || STEP >= (64'd1 << WIDTH)) begin : g_bad_step
        $error("contador: STEP must satisfy 1 <= STEP < 2**WIDTH");
    end
    if (MAX_VAL >= (64'd1 << WIDTH)) begin : g_bad_max
        $error("contador: MAX_VAL must be below 2**WIDTH");
    end
    if (RESET_VAL > MAX_VAL) begin : g_bad_reset
        $error("contador: RESET_VAL must not exceed MAX_VAL");
    end

    localparam logic [WIDTH:0]   STEP_X  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   MAX_X   = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_X = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH:0]   sum;

    // One extra bit on the sum so a carry out of WIDTH bits still counts as past MAX_VAL.
    always_comb begin
        sum     = {1'b0, count_q} + STEP_X;
        count_d = sum[WIDTH-1:0];
        if (sum > MAX_X) begin
            count_d = RESET_X;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RESET_X;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_contador.sv
// Bench for contador: default instance (16-bit, step 1) and a WIDTH=4/STEP=3/MAX_VAL=9 instance
// run side by side, checked every cycle against an arithmetic model of the count sequence.
module tb_contador;

    logic        clk;
    logic        rst_a;
    logic        rst_b;
    logic [15:0] count_a;
    logic [3:0]  count_b;

    int n_checks;
    int n_fail;

    // Edges since the last reset edge; -1 means never reset.
    longint n_a;
    longint n_b;

    logic [31:0] exp_q[$];

    contador u_dut_a (
        .clk   (clk),
        .rst   (rst_a),
        .count (count_a)
    );

    contador #(
        .WIDTH     (4),
        .STEP      (3),
        .RESET_VAL (0),
        .MAX_VAL   (9)
    ) u_dut_b (
        .clk   (clk),
        .rst   (rst_b),
        .count (count_b)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // The legal values are RESET, RESET+STEP, ... up to the last one not above MAX;
    // after n edges the counter sits at position n mod (number of legal values).
    function automatic longint model_val(longint n, longint rv, longint step, longint mx);
        longint len;
        len = (mx - rv) / step + 1;
        return rv + (n % len) * step;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Drive resets, let one rising edge happen, advance the model, then check on the falling edge.
    task automatic cycle(input logic ra, input logic rb);
        rst_a = ra;
        rst_b = rb;
        @(posedge clk);
        if (ra) n_a = 0; else if (n_a >= 0) n_a++;
        if (rb) n_b = 0; else if (n_b >= 0) n_b++;
        if (n_a >= 0) exp_q.push_back(32'(model_val(n_a, 0, 1, 65535)));
        @(negedge clk);
        if (n_a >= 0) check_eq("count_a", 32'(count_a), exp_q.pop_front());
        if (n_b >= 0) check_eq("count_b", 32'(count_b), 32'(model_val(n_b, 0, 3, 9)));
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) cycle(1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] seq_b [6];
        seq_b = '{4'd3, 4'd6, 4'd9, 4'd0, 4'd3, 4'd6};
        n_checks = 0;
        n_fail   = 0;
        n_a      = -1;
        n_b      = -1;

        // Reset held t=0..50: edges at 5..45.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1);
            check_eq("reset_hold_a", 32'(count_a), 32'd0);
        end

        // Released at t=50; 20 edges later (t=250) the count is 20.
        run(20);
        check_eq("t250", 32'(count_a), 32'd20);
        run(10);
        check_eq("t350", 32'(count_a), 32'd30);
        run(10);
        check_eq("t450", 32'(count_a), 32'd40);
        run(5);
        check_eq("t500", 32'(count_a), 32'd45);

        // Mid-count reset, held for 10 edges.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1);
            check_eq("mid_reset_a", 32'(count_a), 32'd0);
            check_eq("mid_reset_b", 32'(count_b), 32'd0);
        end

        // Variant sequence 0,3,6,9,0,3,6 with reset hit mid-sequence.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0);
            check_eq("seq_b", 32'(count_b), 32'(seq_b[i]));
        end
        cycle(1'b0, 1'b1);
        check_eq("seq_b_rst", 32'(count_b), 32'd0);
        cycle(1'b0, 1'b0);
        check_eq("seq_b_after_rst", 32'(count_b), 32'd3);

        // Full wrap of the 16-bit counter.
        cycle(1'b1, 1'b1);
        run(65535);
        check_eq("wrap_top", 32'(count_a), 32'hFFFF);
        cycle(1'b0, 1'b0);
        check_eq("wrap_zero", 32'(count_a), 32'h0000);
        cycle(1'b0, 1'b0);
        check_eq("wrap_one", 32'(count_a), 32'h0001);

        // Random reset pulses on both instances.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
